// File: rtl/sbox_bram_arbiter_if.sv
// Requester-side bus of the S-box BRAM arbiter.
//   req_valid / req_addr  : per-requester lookup request (address slice i*ADDR_W)
//   req_ready             : request i granted this cycle (handshake = valid & ready)
//   rsp_valid / rsp_data  : one-cycle result pulse per requester (data slice i*DATA_W)
// master = requester side, slave = arbiter side.
interface sbox_bram_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ*DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sbox_bram_arbiter.sv
// Shares one dual-port read-only S-box BRAM between NREQ requesters.
// Up to two round-robin grants per cycle (port A, then port B); each result
// is routed back to its owner LAT+1 cycles after the handshake.
// After reset the BRAM output registers are flushed for FLUSH_CYC cycles.
//
// Ports:
//   clk                    : system clock (also the BRAM clock)
//   rst                    : asynchronous active-low reset
//   ifc                    : requester bus (slave side)
//   bram_addra/bram_addrb  : BRAM port addresses
//   bram_en                : BRAM EN / REGCE for both ports
//   bram_rst               : BRAM synchronous output-register reset
//   bram_doa/bram_dob      : BRAM read data
//   busy                   : at least one lookup in flight
//
// state | meaning
// FLUSH | bram_rst high, no grants, flush counter running
// RUN   | normal arbitration, stays here until reset
module sbox_bram_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int LAT       = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sbox_bram_arbiter_if.slave   ifc,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic [ADDR_W-1:0]    bram_addrb,
    output logic                 bram_en,
    output logic                 bram_rst,
    input  logic [DATA_W-1:0]    bram_doa,
    input  logic [DATA_W-1:0]    bram_dob,
    output logic                 busy
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [ID_W:0]    NREQ_X     = (ID_W + 1)'(NREQ);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          flush_cnt;
    logic [ID_W-1:0]           ptr;
    logic [ID_W-1:0]           ptr_nxt;
    logic [ID_W-1:0]           last_id;
    logic [ID_W:0]             scan;
    logic                      gnt_a, gnt_b;
    logic [ID_W-1:0]           id_a, id_b;
    logic [NREQ-1:0]           ready;

    // Per-port tracking pipeline: stage LAT-1 lines up with valid BRAM data.
    logic [LAT-1:0]            trk_a_vld, trk_b_vld;
    logic [LAT-1:0][ID_W-1:0]  trk_a_id, trk_b_id;

    logic [NREQ-1:0]           rsp_vld_q;
    logic [NREQ*DATA_W-1:0]    rsp_data_q;

    // Rotating scan from the pointer; first hit takes port A, second port B.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        id_a  = '0;
        id_b  = '0;
        scan  = '0;
        ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (ID_W + 1)'(k);
            if (scan >= NREQ_X) scan = scan - NREQ_X;
            if (state == RUN && ifc.req_valid[scan[ID_W-1:0]]) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    id_a  = scan[ID_W-1:0];
                end else if (!gnt_b) begin
                    gnt_b = 1'b1;
                    id_b  = scan[ID_W-1:0];
                end
            end
        end
        if (gnt_a) ready[id_a] = 1'b1;
        if (gnt_b) ready[id_b] = 1'b1;
    end

    assign last_id = gnt_b ? id_b : id_a;
    assign ptr_nxt = (last_id == LAST_ID) ? '0 : last_id + ID_W'(1);

    assign bram_addra = gnt_a ? ifc.req_addr[id_a*ADDR_W +: ADDR_W] : '0;
    assign bram_addrb = gnt_b ? ifc.req_addr[id_b*ADDR_W +: ADDR_W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FLUSH;
            flush_cnt  <= FLUSH_LOAD;
            ptr        <= '0;
            trk_a_vld  <= '0;
            trk_b_vld  <= '0;
            trk_a_id   <= '0;
            trk_b_id   <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_cnt == '0) state <= RUN;
                    else                 flush_cnt <= flush_cnt - CNT_W'(1);
                end
                default: state <= RUN;
            endcase

            if (gnt_a) ptr <= ptr_nxt;

            trk_a_vld[0] <= gnt_a;
            trk_a_id[0]  <= id_a;
            trk_b_vld[0] <= gnt_b;
            trk_b_id[0]  <= id_b;
            for (int i = 1; i < LAT; i++) begin
                trk_a_vld[i] <= trk_a_vld[i-1];
                trk_a_id[i]  <= trk_a_id[i-1];
                trk_b_vld[i] <= trk_b_vld[i-1];
                trk_b_id[i]  <= trk_b_id[i-1];
            end

            // A and B never carry the same id in one cycle, so no write clash.
            rsp_vld_q <= '0;
            if (trk_a_vld[LAT-1]) begin
                rsp_vld_q[trk_a_id[LAT-1]]                   <= 1'b1;
                rsp_data_q[trk_a_id[LAT-1]*DATA_W +: DATA_W] <= bram_doa;
            end
            if (trk_b_vld[LAT-1]) begin
                rsp_vld_q[trk_b_id[LAT-1]]                   <= 1'b1;
                rsp_data_q[trk_b_id[LAT-1]*DATA_W +: DATA_W] <= bram_dob;
            end
        end
    end

    assign busy     = (|trk_a_vld) | (|trk_b_vld);
    assign bram_rst = (state == FLUSH);
    // Keeping EN high while anything is in flight means the BRAM never stalls.
    assign bram_en  = gnt_a | busy | (state == FLUSH);

    assign ifc.req_ready = ready;
    assign ifc.rsp_valid = rsp_vld_q;
    assign ifc.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_sbox_bram_arbiter.sv
module tb_sbox_bram_arbiter;
    logic       clk;
    logic       rst;
    logic [9:0] bram_addra, bram_addrb;
    logic       bram_en, bram_rst;
    logic [7:0] bram_doa, bram_dob;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int gcnt [4];

    sbox_bram_arbiter_if #(.NREQ(4), .ADDR_W(10), .DATA_W(8)) ifc ();

    sbox_bram_arbiter #(.NREQ(4), .ADDR_W(10), .DATA_W(8), .LAT(2), .FLUSH_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ifc        (ifc),
        .bram_addra (bram_addra),
        .bram_addrb (bram_addrb),
        .bram_en    (bram_en),
        .bram_rst   (bram_rst),
        .bram_doa   (bram_doa),
        .bram_dob   (bram_dob),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Table contents for the addresses used here.
    function automatic logic [7:0] rom(input logic [9:0] a);
        case (a)
            10'h000: rom = 8'h6A;
            10'h001: rom = 8'h81;
            10'h008: rom = 8'h00;
            default: rom = a[7:0] ^ 8'h5C;
        endcase
    endfunction

    // BRAM model: address register, then output register with sync reset.
    logic [9:0] ra_q, rb_q;
    logic [7:0] doa_q, dob_q;
    always @(posedge clk) begin
        if (bram_en) begin
            ra_q <= bram_addra;
            rb_q <= bram_addrb;
            if (bram_rst) begin
                doa_q <= 8'h00;
                dob_q <= 8'h00;
            end else begin
                doa_q <= rom(ra_q);
                dob_q <= rom(rb_q);
            end
        end
    end
    assign bram_doa = doa_q;
    assign bram_dob = dob_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        ifc.req_addr[i*10 +: 10] = a;
    endtask

    initial begin
        rst           = 1'b0;
        ifc.req_valid = 4'b0001;
        ifc.req_addr  = '0;
        for (int i = 0; i < 4; i++) gcnt[i] = 0;

        // Reset values
        #3;
        chk("rst_ready",    ifc.req_ready, 0);
        chk("rst_rsp_vld",  ifc.rsp_valid, 0);
        chk("rst_rsp_data", ifc.rsp_data, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_addra",    bram_addra, 0);
        chk("rst_addrb",    bram_addrb, 0);
        chk("rst_en",       bram_en, 1);
        chk("rst_bram_rst", bram_rst, 1);

        // Flush then first RUN cycle grants req0 (held through flush)
        @(negedge clk);
        rst = 1'b1;
        edge1();
        @(negedge clk);
        chk("flush_bram_rst", bram_rst, 1);
        chk("flush_ready",    ifc.req_ready, 0);
        edge1();
        @(negedge clk);
        chk("run_bram_rst",   bram_rst, 0);
        chk("single_ready",   ifc.req_ready, 4'b0001);
        chk("single_addra",   bram_addra, 10'h000);
        edge1();
        ifc.req_valid = 4'b0000;
        @(negedge clk);
        chk("single_t1_rsp",  ifc.rsp_valid, 0);
        chk("single_t1_en",   bram_en, 1);
        chk("single_t1_busy", busy, 1);
        edge1();
        @(negedge clk);
        chk("single_t2_rsp",  ifc.rsp_valid, 0);
        chk("single_t2_busy", busy, 1);
        edge1();
        @(negedge clk);
        chk("single_t3_rsp",  ifc.rsp_valid, 4'b0001);
        chk("single_t3_data", ifc.rsp_data[7:0], 8'h6A);
        chk("single_t3_en",   bram_en, 0);
        chk("single_t3_busy", busy, 0);
        edge1();
        @(negedge clk);
        chk("single_t4_rsp",  ifc.rsp_valid, 0);

        // Back-to-back: req3 alone, addresses 0..3
        for (int c = 0; c < 9; c++) begin
            edge1();
            ifc.req_valid = (c < 4) ? 4'b1000 : 4'b0000;
            set_addr(3, 10'(c));
            @(negedge clk);
            chk("b2b_ready", ifc.req_ready, (c < 4) ? 4'b1000 : 4'b0000);
            if (c < 4) chk("b2b_addra", bram_addra, 10'(c));
            if (c >= 3 && c <= 6) begin
                chk("b2b_rsp_vld",  ifc.rsp_valid, 4'b1000);
                chk("b2b_rsp_data", ifc.rsp_data[31:24], rom(10'(c - 3)));
            end else begin
                chk("b2b_rsp_idle", ifc.rsp_valid, 0);
            end
            chk("b2b_en",   bram_en, (c <= 5) ? 1 : 0);
            chk("b2b_busy", busy, (c >= 1 && c <= 5) ? 1 : 0);
        end

        // Fairness: all four valid for 8 cycles, pointer starts at 0
        for (int i = 0; i < 4; i++) set_addr(i, 10'h010 + 10'(i));
        for (int c = 0; c < 12; c++) begin
            edge1();
            ifc.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 8) begin
                chk("fair_ready", ifc.req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
                chk("fair_addra", bram_addra, (c % 2 == 0) ? 10'h010 : 10'h012);
                chk("fair_addrb", bram_addrb, (c % 2 == 0) ? 10'h011 : 10'h013);
                for (int i = 0; i < 4; i++) gcnt[i] += int'(ifc.req_ready[i]);
            end else begin
                chk("fair_idle_ready", ifc.req_ready, 0);
            end
            if (c >= 3 && c <= 10) begin
                chk("fair_rsp_vld", ifc.rsp_valid, ((c - 3) % 2 == 0) ? 4'b0011 : 4'b1100);
                for (int i = 0; i < 4; i++)
                    if (ifc.rsp_valid[i])
                        chk("fair_rsp_data", ifc.rsp_data[i*8 +: 8], rom(10'h010 + 10'(i)));
            end else begin
                chk("fair_rsp_idle", ifc.rsp_valid, 0);
            end
        end
        for (int i = 0; i < 4; i++) chk("fair_count", gcnt[i], 4);

        // Dual grant, pointer at 0: req1 -> A, req2 -> B
        set_addr(1, 10'h001);
        set_addr(2, 10'h008);
        edge1();
        ifc.req_valid = 4'b0110;
        @(negedge clk);
        chk("dual_ready", ifc.req_ready, 4'b0110);
        chk("dual_addra", bram_addra, 10'h001);
        chk("dual_addrb", bram_addrb, 10'h008);
        edge1();
        ifc.req_valid = 4'b0000;
        @(negedge clk);
        chk("dual_t1_rsp", ifc.rsp_valid, 0);
        edge1();
        @(negedge clk);
        chk("dual_t2_rsp", ifc.rsp_valid, 0);
        edge1();
        @(negedge clk);
        chk("dual_t3_rsp",   ifc.rsp_valid, 4'b0110);
        chk("dual_t3_data1", ifc.rsp_data[15:8], 8'h81);
        chk("dual_t3_data2", ifc.rsp_data[23:16], 8'h00);
        edge1();
        @(negedge clk);
        chk("dual_t4_rsp", ifc.rsp_valid, 0);

        // Mid-flight reset one cycle after a dual grant (pointer now 3)
        edge1();
        ifc.req_valid = 4'b0110;
        @(negedge clk);
        chk("mid_ready", ifc.req_ready, 4'b0110);
        edge1();
        ifc.req_valid = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp",      ifc.rsp_valid, 0);
        chk("mid_rst_busy",     busy, 0);
        chk("mid_rst_bram_rst", bram_rst, 1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rsp2", ifc.rsp_valid, 0);
        rst = 1'b1;
        ifc.req_valid = 4'b1001;
        set_addr(0, 10'h020);
        set_addr(3, 10'h030);
        edge1();
        @(negedge clk);
        chk("mid_flush_bram_rst", bram_rst, 1);
        chk("mid_flush_ready",    ifc.req_ready, 0);
        chk("mid_flush_rsp",      ifc.rsp_valid, 0);
        edge1();
        @(negedge clk);
        // Pointer back at 0 puts req0 on A; a stale pointer of 3 would put req3 there.
        chk("mid_run_ready", ifc.req_ready, 4'b1001);
        chk("mid_run_addra", bram_addra, 10'h020);
        chk("mid_run_addrb", bram_addrb, 10'h030);
        chk("mid_run_rsp",   ifc.rsp_valid, 0);
        edge1();
        ifc.req_valid = 4'b0000;
        @(negedge clk);
        chk("mid_t1_rsp", ifc.rsp_valid, 0);
        edge1();
        @(negedge clk);
        chk("mid_t2_rsp", ifc.rsp_valid, 0);
        edge1();
        @(negedge clk);
        chk("mid_t3_rsp",   ifc.rsp_valid, 4'b1001);
        chk("mid_t3_data0", ifc.rsp_data[7:0], 8'h7C);
        chk("mid_t3_data3", ifc.rsp_data[31:24], 8'h6C);
        edge1();
        @(negedge clk);
        chk("mid_t4_rsp", ifc.rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sbox_bram_arbiter.md
Name: sbox_bram_arbiter

Overview:
Shares one dual-port, read-only masked S-box BRAM (x49 table, 10-bit address, 8-bit data, output register enabled) between NREQ requesters, such as state-byte lanes and the key schedule. Each cycle it grants up to two requests in round-robin order, one on port A and one on port B. It drives the BRAM address, enable and reset pins and returns each result to the owning requester after the fixed BRAM latency. After reset, a short flush sequence clears the BRAM output registers before any request is accepted.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 10, BRAM address width
DATA_W, 8, BRAM read data width
LAT, 2, BRAM read latency in cycles (address register plus output register)
FLUSH_CYC, 2, cycles for which bram_rst is held high after reset release

Ports:
clk  in  1  single clock; BRAM clock is the same net
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  request i is pending
req_addr  in  NREQ*ADDR_W  request i address, slice [i*ADDR_W +: ADDR_W]
req_ready  out  NREQ  request i granted this cycle; handshake = valid & ready
rsp_valid  out  NREQ  one-cycle pulse: result for requester i is present
rsp_data  out  NREQ*DATA_W  result for requester i, slice [i*DATA_W +: DATA_W]; meaningful only while rsp_valid[i]
bram_addra  out  ADDR_W  port A address
bram_addrb  out  ADDR_W  port B address
bram_en  out  1  drives BRAM EN (ENA/ENB/REGCEA/REGCEB)
bram_rst  out  1  drives BRAM synchronous output reset
bram_doa  in  DATA_W  port A read data
bram_dob  in  DATA_W  port B read data
busy  out  1  at least one lookup is in flight

Behaviour:
- FSM states: FLUSH, RUN.
  - Asynchronous reset enters FLUSH and loads the flush counter with FLUSH_CYC-1.
  - In FLUSH: bram_rst=1, bram_en=1, req_ready=0. The counter decrements each cycle; the FSM moves to RUN when the counter reaches 0.
  - In RUN: bram_rst=0. The FSM stays in RUN until the next reset.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - bram_addra=bram_addrb=0, bram_en=1, bram_rst=1.
  - Round-robin pointer=0; all pipeline valid bits cleared.
- Arbitration in RUN (combinational from req_valid and the pointer):
  - Scan requesters starting at the pointer, wrapping modulo NREQ.
  - The first valid requester goes to port A; the second goes to port B.
  - If no requester is valid, both addresses are 0 and there is no grant.
  - If only one requester is valid, port A is used and port B carries no request.
  - At most one grant per requester per cycle; req_ready is one-hot or two-hot.
  - The pointer register updates to (last granted index + 1) mod NREQ and holds when there is no grant.
- No starvation: a continuously valid requester is granted within ceil(NREQ/2) cycles.
- Tracking pipeline: a LAT-deep shift register per port carries {valid, requester id} and advances every cycle.
  - At the last stage, a valid entry causes rsp_valid[id]=1 and rsp_data[id] = bram_doa (port A) or bram_dob (port B).
  - Both ports may target distinct ids in the same cycle.
  - These outputs are registered. A handshake at cycle t produces the response at the output register at cycle t+LAT+1, i.e. rsp_valid is seen high in cycle t+3 for LAT=2.
- bram_en = any grant this cycle, OR any valid tracking stage, OR state==FLUSH. The BRAM pipeline therefore never stalls while a lookup is in flight.
- busy = OR of all tracking valid bits.
- Identical addresses on A and B are legal (read-only table, no collision hazard).
- The same requester may issue on consecutive cycles. Responses return in issue order, one per cycle, with no backpressure; requesters must accept them.
- Reset asserted mid-operation: all in-flight lookups are dropped, rsp_valid is forced to 0 asynchronously, and the FSM re-enters FLUSH.
- Write ports are never used; the table is ROM.

Test Plan:
- Reset release: FLUSH_CYC=2.
  - Expect bram_rst=1 for 2 cycles, req_ready=0 throughout, then RUN.
  - A req_valid[0] held during FLUSH is granted on the first RUN cycle.
- Single lookup: req0 addr=0x000 at cycle t.
  - Expect bram_addra=0x000, req_ready=0001.
  - Expect rsp_valid=0001 with rsp_data[7:0]=0x6A at t+3; no other pulse occurs.
- Dual grant:
  - Stimulus: req1 addr=0x001 and req2 addr=0x008 simultaneously, pointer=0.
  - Expect port A→req1, port B→req2, req_ready=0110.
  - Expect at t+3 rsp_data[15:8]=0x81 and rsp_data[23:16]=0x00, both valid.
- Fairness: all 4 requesters held valid for 8 cycles.
  - Expect grant pairs (0,1),(2,3),(0,1),...
  - Expect each requester granted exactly 4 times; responses match the table for their addresses.
- Back-to-back: req3 valid on every cycle alone, addresses 0x000,0x001,...
  - Expect one grant per cycle and in-order responses 0x6A, 0x81, ...
  - Expect bram_en to remain 1 until 3 cycles after the last grant, then 0; busy follows.
- Mid-flight reset: assert rst low one cycle after a dual grant.
  - Expect no rsp_valid pulse for the dropped lookups.
  - Expect the FSM to re-enter FLUSH and the pointer to return to 0.
